// File: rtl/sparse_compaction_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// sparse_compaction_scheduler_pkg
//   Shared constants and helpers for the sparse compaction scheduler:
//   default geometry (mask length, rank width, element width, lanes),
//   the beat-counter width helper, the FSM state encoding and the
//   lane-select helper that maps (beat, lane) to the rank it must pick.
// ---------------------------------------------------------------------------
package sparse_compaction_scheduler_pkg;

  localparam int SCS_BITMASK_LENGTH = 16;
  localparam int SCS_INDEX_BITWIDTH = 5;
  localparam int SCS_ELEM_WIDTH     = 8;
  localparam int SCS_LANES          = 4;

  // FSM encoding kept as plain constants so older tools can consume it.
  typedef logic [0:0] scs_state_t;
  localparam scs_state_t ST_IDLE = 1'b0;
  localparam scs_state_t ST_EMIT = 1'b1;

  // Beat counter must hold BITMASK_LENGTH/LANES (the full-mask beat count).
  function automatic int scs_beat_width(input int bitmask_length, input int lanes);
    return $clog2(bitmask_length / lanes) + 1;
  endfunction

  // Inclusive rank that lane `lane` of beat `beat` must select.
  function automatic logic [31:0] lane_target(input logic [31:0] beat,
                                              input logic [31:0] lane,
                                              input logic [31:0] lanes);
    return (beat * lanes) + lane + 32'd1;
  endfunction

endpackage

// File: rtl/sparse_compaction_scheduler_if.sv
// ---------------------------------------------------------------------------
// sparse_compaction_scheduler_if
//   Groups the input-block handshake and the output-beat stream.
//   slave  : the scheduler's view (consumes blocks, produces beats)
//   master : the environment's view (offers blocks, consumes beats)
//   Signals: in_valid/in_ready/in_bitmask/in_data,
//            out_valid/out_ready/out_data/out_lane_valid/out_last
// ---------------------------------------------------------------------------
interface sparse_compaction_scheduler_if
  import sparse_compaction_scheduler_pkg::*;
#(
  parameter int BITMASK_LENGTH = SCS_BITMASK_LENGTH,
  parameter int ELEM_WIDTH     = SCS_ELEM_WIDTH,
  parameter int LANES          = SCS_LANES
);

  logic                                 in_valid;
  logic                                 in_ready;
  logic [BITMASK_LENGTH-1:0]            in_bitmask;
  logic [BITMASK_LENGTH*ELEM_WIDTH-1:0] in_data;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [LANES*ELEM_WIDTH-1:0]          out_data;
  logic [LANES-1:0]                     out_lane_valid;
  logic                                 out_last;

  modport slave (
    input  in_valid, in_bitmask, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lane_valid, out_last
  );

  modport master (
    output in_valid, in_bitmask, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lane_valid, out_last
  );

endinterface

// File: rtl/sparse_compaction_scheduler_select_gen.sv
// ---------------------------------------------------------------------------
// sparse_compaction_scheduler_select_gen  (selectGenerator)
//   Purely combinational prefix-count unit: rank[i] = popcount(mask[i:0]).
//   The top registers these ranks when a block is accepted.
//   Ports:
//     mask  in   BITMASK_LENGTH                  nonzero bitmask
//     rank  out  BITMASK_LENGTH x INDEX_BITWIDTH inclusive ranks
// ---------------------------------------------------------------------------
module sparse_compaction_scheduler_select_gen
  import sparse_compaction_scheduler_pkg::*;
#(
  parameter int BITMASK_LENGTH = SCS_BITMASK_LENGTH,
  parameter int INDEX_BITWIDTH = SCS_INDEX_BITWIDTH
) (
  input  logic [BITMASK_LENGTH-1:0]                     mask,
  output logic [BITMASK_LENGTH-1:0][INDEX_BITWIDTH-1:0] rank
);

  // Running popcount across the mask, bit 0 first.
  always_comb begin
    logic [INDEX_BITWIDTH-1:0] acc;
    acc  = '0;
    rank = '0;
    for (int i = 0; i < BITMASK_LENGTH; i++) begin
      acc     = acc + INDEX_BITWIDTH'(mask[i]);
      rank[i] = acc;
    end
  end

endmodule

// File: rtl/sparse_compaction_scheduler.sv
// ---------------------------------------------------------------------------
// sparse_compaction_scheduler
//   Accepts one dense block (elements + nonzero bitmask) per handshake and
//   streams its nonzero elements in mask order, LANES per beat, with a last
//   flag on the final beat of each block.
//   Ports:
//     clock  in   rising-edge clock
//     reset  in   synchronous, active-high
//     bus    slave modport of sparse_compaction_scheduler_if
//     busy   out  high while a block is being emitted
//   Configuration macro: SPARSE_SCHED_EMPTY_BEAT_EN
//     defined   : an all-zero mask emits one empty beat with out_last=1
//     undefined : an all-zero mask is swallowed in one cycle, no beat
// ---------------------------------------------------------------------------
module sparse_compaction_scheduler
  import sparse_compaction_scheduler_pkg::*;
#(
  parameter int BITMASK_LENGTH = SCS_BITMASK_LENGTH,
  parameter int INDEX_BITWIDTH = SCS_INDEX_BITWIDTH,
  parameter int ELEM_WIDTH     = SCS_ELEM_WIDTH,
  parameter int LANES          = SCS_LANES
) (
  input  logic                          clock,
  input  logic                          reset,
  sparse_compaction_scheduler_if.slave  bus,
  output logic                          busy
);

  localparam int BEAT_W = scs_beat_width(BITMASK_LENGTH, LANES);
  localparam int DATA_W = BITMASK_LENGTH * ELEM_WIDTH;
  localparam int OUT_W  = LANES * ELEM_WIDTH;

`ifdef SPARSE_SCHED_EMPTY_BEAT_EN
  localparam bit EMPTY_BEAT_EN = 1'b1;
`else
  localparam bit EMPTY_BEAT_EN = 1'b0;
`endif

  // Registered state
  scs_state_t                                   state_q, state_d;
  logic [BEAT_W-1:0]                            beat_q, beat_d;
  logic [BEAT_W-1:0]                            nbeats_q, nbeats_d;
  logic [INDEX_BITWIDTH-1:0]                    nnz_q, nnz_d;
  logic [BITMASK_LENGTH-1:0]                    mask_q, mask_d;
  logic [DATA_W-1:0]                            data_q, data_d;
  logic [BITMASK_LENGTH-1:0][INDEX_BITWIDTH-1:0] rank_q, rank_d;
  logic                                         out_valid_q, out_valid_d;
  logic [OUT_W-1:0]                             out_data_q, out_data_d;
  logic [LANES-1:0]                             out_lane_valid_q, out_lane_valid_d;
  logic                                         out_last_q, out_last_d;

  // Combinational
  logic [BITMASK_LENGTH-1:0][INDEX_BITWIDTH-1:0] in_rank_s;
  logic [INDEX_BITWIDTH-1:0]                    in_nnz_s;
  logic [BEAT_W-1:0]                            in_nbeats_s;
  logic                                         in_ready_s;
  logic                                         accept_s;
  logic                                         emit_s;
  logic                                         out_fire_s;
  logic [BITMASK_LENGTH-1:0]                    src_mask_s;
  logic [DATA_W-1:0]                            src_data_s;
  logic [BITMASK_LENGTH-1:0][INDEX_BITWIDTH-1:0] src_rank_s;
  logic [INDEX_BITWIDTH-1:0]                    src_nnz_s;
  logic [BEAT_W-1:0]                            src_nbeats_s;
  logic [BEAT_W-1:0]                            src_beat_s;
  logic [OUT_W-1:0]                             beat_data_s;
  logic [LANES-1:0]                             beat_lane_valid_s;
  logic                                         beat_last_s;

  sparse_compaction_scheduler_select_gen #(
    .BITMASK_LENGTH (BITMASK_LENGTH),
    .INDEX_BITWIDTH (INDEX_BITWIDTH)
  ) u_select_gen (
    .mask (bus.in_bitmask),
    .rank (in_rank_s)
  );

  assign in_nnz_s = in_rank_s[BITMASK_LENGTH-1];

  // Beat count of the incoming block; an empty block may still own one beat.
  always_comb begin
    if (EMPTY_BEAT_EN && (in_nnz_s == '0)) begin
      in_nbeats_s = BEAT_W'(1);
    end else begin
      in_nbeats_s = BEAT_W'((32'(in_nnz_s) + 32'(LANES) - 32'd1) / 32'(LANES));
    end
  end

  // Handshake decode. A new block may enter while the last beat of the
  // current one is being consumed, giving gap-free back-to-back blocks.
  always_comb begin
    in_ready_s = (state_q == ST_IDLE) || (out_valid_q && bus.out_ready && out_last_q);
    accept_s   = bus.in_valid && in_ready_s;
    emit_s     = accept_s && ((in_nnz_s != '0) || EMPTY_BEAT_EN);
    out_fire_s = out_valid_q && bus.out_ready;
  end

  // The next beat comes either from the block being accepted (beat 0) or
  // from the stored block (current beat + 1); one lane mux serves both.
  always_comb begin
    if (accept_s) begin
      src_mask_s   = bus.in_bitmask;
      src_data_s   = bus.in_data;
      src_rank_s   = in_rank_s;
      src_nnz_s    = in_nnz_s;
      src_nbeats_s = in_nbeats_s;
      src_beat_s   = '0;
    end else begin
      src_mask_s   = mask_q;
      src_data_s   = data_q;
      src_rank_s   = rank_q;
      src_nnz_s    = nnz_q;
      src_nbeats_s = nbeats_q;
      src_beat_s   = beat_q + BEAT_W'(1);
    end
  end

  // Lane mux: lane j takes the masked element whose rank equals its target.
  // At most one element matches, so an AND-OR reduction is sufficient and
  // lanes beyond nnz naturally resolve to zero.
  always_comb begin
    logic [31:0] target;
    logic        hit;
    target            = 32'd0;
    hit               = 1'b0;
    beat_data_s       = '0;
    beat_lane_valid_s = '0;
    for (int j = 0; j < LANES; j++) begin
      target = lane_target(32'(src_beat_s), 32'(j), 32'(LANES));
      beat_lane_valid_s[j] = (target <= 32'(src_nnz_s));
      for (int i = 0; i < BITMASK_LENGTH; i++) begin
        hit = src_mask_s[i] && (32'(src_rank_s[i]) == target);
        beat_data_s[j*ELEM_WIDTH +: ELEM_WIDTH] = beat_data_s[j*ELEM_WIDTH +: ELEM_WIDTH]
                                                 | (src_data_s[i*ELEM_WIDTH +: ELEM_WIDTH] & {ELEM_WIDTH{hit}});
      end
    end
    beat_last_s = (src_beat_s == (src_nbeats_s - BEAT_W'(1)));
  end

  // FSM and output-register next-state.
  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    nbeats_d         = nbeats_q;
    nnz_d            = nnz_q;
    mask_d           = mask_q;
    data_d           = data_q;
    rank_d           = rank_q;
    out_valid_d      = out_valid_q;
    out_data_d       = out_data_q;
    out_lane_valid_d = out_lane_valid_q;
    out_last_d       = out_last_q;
    if (emit_s) begin
      state_d          = ST_EMIT;
      beat_d           = '0;
      nbeats_d         = in_nbeats_s;
      nnz_d            = in_nnz_s;
      mask_d           = bus.in_bitmask;
      data_d           = bus.in_data;
      rank_d           = in_rank_s;
      out_valid_d      = 1'b1;
      out_data_d       = beat_data_s;
      out_lane_valid_d = beat_lane_valid_s;
      out_last_d       = beat_last_s;
    end else if (accept_s || (out_fire_s && out_last_q)) begin
      // Block finished, or an empty block swallowed without a beat.
      state_d          = ST_IDLE;
      beat_d           = '0;
      out_valid_d      = 1'b0;
      out_data_d       = '0;
      out_lane_valid_d = '0;
      out_last_d       = 1'b0;
    end else if (out_fire_s) begin
      beat_d           = src_beat_s;
      out_data_d       = beat_data_s;
      out_lane_valid_d = beat_lane_valid_s;
      out_last_d       = beat_last_s;
    end else begin
      // Idle with no offer, or stalled: everything holds.
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      beat_q           <= '0;
      nbeats_q         <= '0;
      nnz_q            <= '0;
      mask_q           <= '0;
      data_q           <= '0;
      rank_q           <= '0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_lane_valid_q <= '0;
      out_last_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_q           <= beat_d;
      nbeats_q         <= nbeats_d;
      nnz_q            <= nnz_d;
      mask_q           <= mask_d;
      data_q           <= data_d;
      rank_q           <= rank_d;
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
      out_lane_valid_q <= out_lane_valid_d;
      out_last_q       <= out_last_d;
    end
  end

  assign bus.in_ready       = in_ready_s;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_lane_valid = out_lane_valid_q;
  assign bus.out_last       = out_last_q;
  assign busy               = (state_q == ST_EMIT);

endmodule
